cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
Multi-cycle control-unit FSM for the 19-bit CPU. It sequences fetch/decode/execute/memory/writeback and drives the control bus strobes (rd_en, wr_en, inc_pc, load_reg, mode) from the 5-bit opcode and the 4-bit ALU flags. It sits between the instruction register/ALU flags and the memory, PC, register file and ALU. It adds a memory-ready handshake with a timeout watchdog and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory wait state (>=1)
COUNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  run request; sampled at instruction boundaries
opcode  input  5  current instruction opcode; valid in DECODE
flags  input  4  ALU flags [0]=Z [1]=N [2]=C [3]=V
mem_ready  input  1  memory completes the current rd_en/wr_en access this cycle
rd_en  output  1  memory read strobe (fetch or load)
wr_en  output  1  memory write strobe (store)
inc_pc  output  1  PC increment pulse
load_pc  output  1  PC load pulse (taken jump/branch)
load_reg  output  1  register-file write pulse
alu_en  output  1  ALU execute pulse
mode  output  1  ALU mode, valid while alu_en=1 (0 = arithmetic, 1 = logic)
illegal_op  output  1  one-cycle pulse on undefined opcode
bus_err  output  1  sticky memory-timeout error
halted  output  1  sticky halt indicator
state  output  4  current state encoding (debug)
instr_count  output  COUNT_W  retired instructions, wraps at 2^COUNT_W

Behaviour:
- Reset: state=IDLE(0), all outputs 0, instr_count=0, timeout counter=0, latched opcode=0. Reset overrides every state, including HALTED and mid-wait.
- Outputs are Moore, decoded from state and latched opcode. Pulses last exactly 1 cycle.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM_RD=4, MEM_WR=5, BRANCH=6, WRITEBACK=7, HALTED=8.
- IDLE: enable=1 -> FETCH; otherwise stay.
- FETCH: rd_en=1. mem_ready=1 -> DECODE.
- DECODE: latch opcode, inc_pc=1. Next state by opcode:
  - 0x00 NOP -> boundary.
  - 0x01-0x0F ALU -> EXECUTE.
  - 0x10 LOAD -> MEM_RD.
  - 0x11 STORE -> MEM_WR.
  - 0x12 JMP, 0x13 BEQ, 0x14 BNE, 0x15 BC -> BRANCH.
  - 0x1F HALT -> HALTED, counted as retired.
  - 0x16-0x1E: illegal_op=1, then treated as NOP.
- EXECUTE: alu_en=1, mode=opcode_q[3] -> WRITEBACK.
- MEM_RD: rd_en=1 until mem_ready -> WRITEBACK.
- MEM_WR: wr_en=1 until mem_ready -> boundary.
- BRANCH: flags sampled this cycle. load_pc=1 if JMP, BEQ&Z, BNE&!Z, or BC&C -> boundary.
- WRITEBACK: load_reg=1 -> boundary.
- Boundary (instruction completion):
  - instr_count+1.
  - Next state FETCH if enable=1, else IDLE. enable dropping mid-instruction never aborts it.
- Latencies with zero-wait memory:
  - NOP/illegal: 2 cycles.
  - STORE, branch: 3 cycles.
  - ALU, LOAD: 4 cycles.
  - Each wait cycle adds 1.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- Timeout:
  - Counter clears on entry to each wait state and increments each cycle with mem_ready=0.
  - When count reaches MEM_TIMEOUT with mem_ready still 0: strobe drops next cycle, bus_err=1, halted=1, state=HALTED, instruction not counted.
  - mem_ready=1 in the same cycle the limit is reached wins (access completes normally).
- HALTED: all strobes 0, halted=1, ignores enable; exit only via rst.
- rd_en and wr_en are never both 1. inc_pc and load_pc are never both 1.

Test Plan:
- Reset: rst=1 for 2 cycles, enable=0 for 5 more -> all outputs 0, state=0, instr_count=0 throughout.
- ALU 0x09, mem_ready=1, enable=1 -> rd_en in cycle 1, inc_pc in cycle 2, alu_en=1/mode=1 in cycle 3, load_reg in cycle 4, instr_count=1, state=1 in cycle 5.
- LOAD 0x10, mem_ready low for 3 cycles in MEM_RD -> rd_en held 4 cycles, load_reg on the following cycle, instr_count+1. STORE 0x11 zero-wait -> wr_en for 1 cycle, no load_reg.
- BEQ 0x13 with flags=4'b0001 -> load_pc=1 in BRANCH. Same with flags=4'b0000 -> load_pc=0. BC with flags=4'b0100 -> load_pc=1. Each takes 3 cycles.
- MEM_TIMEOUT=8, mem_ready=0 in FETCH -> rd_en high for 8 cycles then 0, bus_err=1, halted=1, state=8; enable toggling has no effect; rst clears all outputs.
- Opcode 0x18 -> illegal_op pulse, retires as NOP (instr_count+1). enable dropped during EXECUTE -> WRITEBACK completes, then state=0. HALT 0x1F -> halted=1, instr_count+1.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/execute control FSM with memory watchdog
module cpu_control_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [4:0]         opcode,
    input  logic [3:0]         flags,
    input  logic               mem_ready,
    output logic               rd_en,
    output logic               wr_en,
    output logic               inc_pc,
    output logic               load_pc,
    output logic               load_reg,
    output logic               alu_en,
    output logic               mode,
    output logic               illegal_op,
    output logic               bus_err,
    output logic               halted,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXECUTE   = 4'd3,
        MEM_RD    = 4'd4,
        MEM_WR    = 4'd5,
        BRANCH    = 4'd6,
        WRITEBACK = 4'd7,
        HALTED    = 4'd8
    } state_t;
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    state_t             state_q, state_d;
    logic [4:0]         opcode_q, opcode_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               bus_err_q, bus_err_d;
    logic               waiting, expired, fin, taken, bad_op;
    logic               unused_flags;
    assign unused_flags = ^{flags[1], flags[3]};
    // Next-state, watchdog and retire logic; fin marks an instruction boundary
    always_comb begin
        waiting   = state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR;
        expired   = waiting && !mem_ready && tmo_q == TW'(MEM_TIMEOUT - 1);
        bad_op    = opcode >= 5'h16 && opcode <= 5'h1E;
        taken     = opcode_q == 5'h12 || (opcode_q == 5'h13 && flags[0]) ||
                    (opcode_q == 5'h14 && !flags[0]) || (opcode_q == 5'h15 && flags[2]);
        opcode_d  = state_q == DECODE ? opcode : opcode_q;
        fin       = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE:      state_d = enable ? FETCH : IDLE;
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                fin     = opcode == 5'h00 || bad_op;
                state_d = opcode == 5'h1F ? HALTED :
                          opcode <= 5'h0F ? EXECUTE :
                          opcode == 5'h10 ? MEM_RD :
                          opcode == 5'h11 ? MEM_WR : BRANCH;
            end
            EXECUTE:   state_d = WRITEBACK;
            MEM_RD:    state_d = mem_ready ? WRITEBACK : MEM_RD;
            MEM_WR:    fin = mem_ready;
            BRANCH:    fin = 1'b1;
            WRITEBACK: fin = 1'b1;
            default:   state_d = HALTED;
        endcase
        if (fin) state_d = enable ? FETCH : IDLE;
        if (expired) state_d = HALTED;
        count_d   = count_q + COUNT_W'(fin || (state_q == DECODE && opcode == 5'h1F));
        bus_err_d = bus_err_q | expired;
        tmo_d     = state_d != state_q ? '0 : tmo_q + TW'(waiting && !mem_ready);
    end
    // State, latched opcode, watchdog count, retire count and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            tmo_q     <= '0;
            count_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            tmo_q     <= tmo_d;
            count_q   <= count_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign rd_en       = state_q == FETCH || state_q == MEM_RD;
    assign wr_en       = state_q == MEM_WR;
    assign inc_pc      = state_q == DECODE;
    assign load_pc     = state_q == BRANCH && taken;
    assign load_reg    = state_q == WRITEBACK;
    assign alu_en      = state_q == EXECUTE;
    assign mode        = state_q == EXECUTE && opcode_q[3];
    assign illegal_op  = state_q == DECODE && bad_op;
    assign bus_err     = bus_err_q;
    assign halted      = state_q == HALTED;
    assign state       = state_q;
    assign instr_count = count_q;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: randomized and directed checks against a per-instruction trace model
module tb_cpu_control_sequencer;
    logic        clk = 1'b0;
    logic        rst, enable, mem_ready;
    logic [4:0]  opcode;
    logic [3:0]  flags;
    logic        rd_en, wr_en, inc_pc, load_pc, load_reg, alu_en, mode, illegal_op, bus_err, halted;
    logic [3:0]  state;
    logic [15:0] instr_count;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_m;
    logic        idle_m;
    cpu_control_sequencer #(.MEM_TIMEOUT(8), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .opcode(opcode), .flags(flags),
        .mem_ready(mem_ready), .rd_en(rd_en), .wr_en(wr_en), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_reg(load_reg), .alu_en(alu_en), .mode(mode),
        .illegal_op(illegal_op), .bus_err(bus_err), .halted(halted), .state(state),
        .instr_count(instr_count)
    );
    always #5 clk = ~clk;
    wire [13:0] obs = {rd_en, wr_en, inc_pc, load_pc, load_reg, alu_en, mode, illegal_op,
                       bus_err, halted, state};
    // Expected output vector for one cycle, same packing as obs
    function automatic logic [13:0] ov(input logic [3:0] st, input logic rd, wr, inc, lpc, lreg,
                                       alu, md, ill, be, hl);
        return {rd, wr, inc, lpc, lreg, alu, md, ill, be, hl, st};
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask
    // Check one cycle at the negedge, then drive inputs sampled at the coming posedge
    task automatic cyc(input string tag, input logic [13:0] e, input logic mr, input logic en);
        chk(tag, {18'b0, obs}, {18'b0, e});
        chk({tag, "_count"}, {16'b0, instr_count}, {16'b0, cnt_m});
        mem_ready = mr;
        enable    = en;
        @(negedge clk);
    endtask
    function automatic logic rb();
        return 1'($urandom);
    endfunction
    // Expand one instruction into its expected cycle trace from the opcode rules
    task automatic instr(input logic [4:0] op, input logic [3:0] fl, input int fw, input int mw,
                         input logic keep);
        logic ill, tk;
        opcode = op;
        flags  = fl;
        ill = op >= 5'h16 && op <= 5'h1E;
        tk  = op == 5'h12 || (op == 5'h13 && fl[0]) || (op == 5'h14 && !fl[0]) ||
              (op == 5'h15 && fl[2]);
        if (idle_m) cyc("idle", ov(0, 0,0,0,0,0,0,0,0,0,0), rb(), 1'b1);
        for (int i = 0; i <= fw; i++) cyc("fetch", ov(1, 1,0,0,0,0,0,0,0,0,0), i == fw, keep);
        cyc("decode", ov(2, 0,0,1,0,0,0,0,ill,0,0), rb(), keep);
        if (op >= 5'h01 && op <= 5'h0F) begin
            cyc("execute", ov(3, 0,0,0,0,0,1,op[3],0,0,0), rb(), keep);
            cyc("writeback", ov(7, 0,0,0,0,1,0,0,0,0,0), rb(), keep);
        end else if (op == 5'h10) begin
            for (int i = 0; i <= mw; i++) cyc("mem_rd", ov(4, 1,0,0,0,0,0,0,0,0,0), i == mw, keep);
            cyc("writeback", ov(7, 0,0,0,0,1,0,0,0,0,0), rb(), keep);
        end else if (op == 5'h11) begin
            for (int i = 0; i <= mw; i++) cyc("mem_wr", ov(5, 0,1,0,0,0,0,0,0,0,0), i == mw, keep);
        end else if (op >= 5'h12 && op <= 5'h15) begin
            cyc("branch", ov(6, 0,0,0,tk,0,0,0,0,0,0), rb(), keep);
        end
        cnt_m++;
        idle_m = !keep;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        cnt_m  = '0;
        idle_m = 1'b1;
        cyc("post_reset", ov(0, 0,0,0,0,0,0,0,0,0,0), rb(), rb());
        rst    = 1'b0;
    endtask
    initial begin
        rst = 1'b1; enable = 1'b0; mem_ready = 1'b0; opcode = '0; flags = '0;
        cnt_m = '0; idle_m = 1'b1;
        @(negedge clk);
        cyc("reset", ov(0, 0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc("reset_idle", ov(0, 0,0,0,0,0,0,0,0,0,0), rb(), 1'b0);
        instr(5'h09, 4'h0, 0, 0, 1'b1);
        instr(5'h10, 4'h0, 0, 3, 1'b1);
        instr(5'h11, 4'h0, 0, 0, 1'b1);
        instr(5'h13, 4'b0001, 0, 0, 1'b1);
        instr(5'h13, 4'b0000, 0, 0, 1'b1);
        instr(5'h15, 4'b0100, 0, 0, 1'b1);
        instr(5'h14, 4'b0000, 0, 0, 1'b1);
        instr(5'h12, 4'b0000, 0, 0, 1'b1);
        instr(5'h18, 4'h0, 0, 0, 1'b1);
        instr(5'h00, 4'h0, 7, 0, 1'b1);
        instr(5'h10, 4'h0, 0, 7, 1'b1);
        instr(5'h11, 4'h0, 2, 7, 1'b1);
        instr(5'h02, 4'h0, 0, 0, 1'b0);
        instr(5'h0C, 4'h0, 1, 0, 1'b1);
        for (int n = 0; n < 60; n++)
            instr(5'($urandom_range(0, 30)), 4'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
        instr(5'h1F, 4'h0, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            opcode = 5'($urandom);
            cyc("halt_hold", ov(8, 0,0,0,0,0,0,0,0,0,1), rb(), rb());
        end
        do_reset();
        opcode = 5'h09;
        cyc("idle", ov(0, 0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc("tmo_fetch", ov(1, 1,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc("tmo_halt", ov(8, 0,0,0,0,0,0,0,0,1,1), rb(), rb());
        do_reset();
        instr(5'h01, 4'h0, 0, 0, 1'b1);
        opcode = 5'h10;
        cyc("fetch", ov(1, 1,0,0,0,0,0,0,0,0,0), 1'b1, 1'b1);
        cyc("decode", ov(2, 0,0,1,0,0,0,0,0,0,0), 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc("tmo_mem_rd", ov(4, 1,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("tmo_rd_halt", ov(8, 0,0,0,0,0,0,0,0,1,1), rb(), rb());
        do_reset();
        cyc("final_idle", ov(0, 0,0,0,0,0,0,0,0,0,0), rb(), 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
